// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serial transmitter with valid/ready byte input
`timescale 1ns/1ps

module uart_tx #(
  parameter int DIV    = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy
);

  // Period counter only needs to reach DIV-1, so DIV=65535 fits in 16 bits.
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              period_end;

  assign period_end = (cnt_q == CNT_LAST);
  assign in_ready   = (state_q == IDLE);
  assign tx         = tx_q;
  assign busy       = busy_q;

  // Next-state logic; tx_d/busy_d describe the line for the cycle after the edge,
  // so the registered outputs change on the same edge as the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (in_valid) begin
          shift_d = in_data;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        cnt_d = period_end ? '0 : cnt_q + 1'b1;
        if (period_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        cnt_d = period_end ? '0 : cnt_q + 1'b1;
        if (period_end) begin
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
      STOP: begin
        cnt_d = period_end ? '0 : cnt_q + 1'b1;
        tx_d  = 1'b1;
        if (period_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset forces the line to mark immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter: 8N1 frames (start, 8 data bits LSB first, stop) from a parallel byte stream.
- Byte input uses a valid/ready handshake.
- Driven by a 4-state FSM with a bit-period counter and a shift register.
- Sits at the output edge of the design, feeding the serial line that the companion receiver FSM consumes.

Parameters:
- DIV, 16, clock cycles per bit period; legal range 2..65535.
- DATA_W, 8, data bits per frame; legal range 5..9.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DATA_W  byte to send; sampled only on acceptance.
- in_valid  input  1  in_data holds a byte to send.
- in_ready  output  1  transmitter can accept a byte this cycle.
- tx  output  1  serial line; idle/mark = 1.
- busy  output  1  high while a frame is in flight (START, DATA, STOP).

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset (asynchronous, immediate on rst rise, held while rst=1):
  - state=IDLE, tx=1, busy=0, in_ready=1.
  - Bit counter, period counter and shift register = 0.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - in_ready=1, tx=1.
  - On in_valid&&in_ready: latch in_data into the shift register, clear the period counter and bit counter, go to START.
- START:
  - tx=0 for exactly DIV cycles, then go to DATA.
- DATA:
  - tx = shift register bit 0 for DIV cycles.
  - At the end of each period: shift right by 1, increment the bit counter.
  - After DATA_W periods, go to STOP.
- STOP:
  - tx=1 for DIV cycles, then go to IDLE.
- Outputs:
  - tx and busy are registered outputs.
  - in_ready is combinational from state (== IDLE).
- Timing:
  - Acceptance edge at cycle N: tx=0 from cycle N+1.
  - Total frame = (DATA_W+2)*DIV cycles.
  - busy=1 from cycle N+1 through the final STOP cycle.
- Back-to-back: acceptance happens only in IDLE. With in_valid held continuously, there is exactly 1 idle cycle (tx=1) between the end of the stop bit and the next start bit, i.e. the effective stop length is DIV+1.
- Backpressure:
  - in_valid while in_ready=0 is ignored; no byte is captured or lost internally.
  - The source must hold in_valid until handshake completion.
- Data stability: in_data changes after the acceptance edge do not affect the frame in flight.
- Period counter: width ceil(log2(DIV)); counts 0..DIV-1 and wraps to 0 at each bit boundary. The counter must not overflow for DIV=65535.
- Reset mid-frame: tx returns to 1 and busy to 0 immediately. The partial frame is abandoned and not resumed. On rst deassertion the FSM is in IDLE with in_ready=1.
- in_valid asserted during the reset-deassert cycle: accepted on the first clk edge with rst=0.
- No parity, no break generation, no FIFO: exactly one byte is buffered.

Test Plan:
- DIV=4, send 0x55 -> tx sequence per 4-cycle period: 0,1,0,1,0,1,0,1,0,1. Total 40 cycles; busy high 40 cycles, then in_ready=1.
- DIV=4, in_valid held with 0xA3 then 0x0F -> frames 0,1,1,0,0,0,1,0,1,1 and 0,1,1,1,1,0,0,0,0,1. Exactly 1 idle-high cycle between the two frames.
- DIV=4, send 0x81 and assert in_valid with 0xFF during DATA -> 0xFF ignored; the frame stays 0x81; 0xFF is accepted only on the next IDLE cycle.
- DIV=8, send 0x00; pulse rst at cycle 30 of the frame -> tx=1 and busy=0 in the same cycle. After release, in_ready=1; a new 0x3C frame transmits correctly.
- DIV=2, DATA_W=8, send 0xFF -> start bit 2 cycles low, then tx high for 18 cycles. busy deasserts exactly 20 cycles after the acceptance edge.
- Change in_data to 0x00 the cycle after accepting 0xC5 -> the transmitted bits still decode as 0xC5.
